// File: rtl/agc_pkg.sv
// Shared helpers for the AGC saturation monitoring path: count width sizing
// and the integer-field codes the fixed-point cast produces on saturation.
package agc_pkg;

    function automatic int cnt_width(input int window_log2, input int parallel);
        return window_log2 + $clog2(parallel) + 1;
    endfunction

    // Positive saturation integer field: sign clear, all magnitude bits set.
    function automatic logic [31:0] pos_sat_code(input int din_int);
        return (32'd1 << (din_int - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] neg_sat_code(input int din_int);
        return 32'd1 << (din_int - 1);
    endfunction

endpackage

// File: rtl/sat_lane_classify.sv
// Single-lane saturation classifier: flags a word whose integer field equals
// the positive or negative saturation code; fractional bits do not matter.
module sat_lane_classify
    import agc_pkg::*;
#(
    parameter int DIN_WIDTH = 16,
    parameter int DIN_INT   = 5
)(
    input  logic [DIN_WIDTH-1:0] din,
    output logic                 pos_sat,
    output logic                 neg_sat
);

    localparam logic [DIN_INT-1:0] POS_CODE = DIN_INT'(pos_sat_code(DIN_INT));
    localparam logic [DIN_INT-1:0] NEG_CODE = DIN_INT'(neg_sat_code(DIN_INT));

    logic [DIN_INT-1:0] int_field_s;
    logic               unused_frac_s;

    assign int_field_s   = din[DIN_WIDTH-1 -: DIN_INT];
    assign unused_frac_s = ^din[DIN_WIDTH-DIN_INT-1:0];
    assign pos_sat       = (int_field_s == POS_CODE);
    assign neg_sat       = (int_field_s == NEG_CODE);

endmodule

// File: rtl/sat_monitor.sv
// Counts positive/negative saturated lane samples per integration window and
// hands the per-window totals plus a threshold flag to AGC control.
module sat_monitor
    import agc_pkg::*;
#(
    parameter int  PARALLEL    = 4,
    parameter int  DIN_WIDTH   = 16,
    parameter int  DIN_INT     = 5,
    parameter int  WINDOW_LOG2 = 10,
    localparam int CNT_W       = cnt_width(WINDOW_LOG2, PARALLEL)
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIN_WIDTH*PARALLEL-1:0] din,
    input  logic                          din_valid,
    input  logic                          clear,
    input  logic [CNT_W-1:0]              thresh,
    output logic [CNT_W-1:0]              pos_count,
    output logic [CNT_W-1:0]              neg_count,
    output logic                          over_thresh,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          overrun
);

    localparam int PC_W = $clog2(PARALLEL) + 1;
    localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;

    logic [PARALLEL-1:0]    pos_flags_s, neg_flags_s;
    logic [PARALLEL-1:0]    pos_flags_r, neg_flags_r;
    logic                   s1_valid_r;
    logic [PC_W-1:0]        pos_pc_s, neg_pc_s;
    logic [PC_W-1:0]        pos_pc_r, neg_pc_r;
    logic                   s2_valid_r;
    logic [WINDOW_LOG2-1:0] win_cnt_r;
    logic [CNT_W-1:0]       pos_acc_r, neg_acc_r;
    logic [CNT_W-1:0]       pos_total_s, neg_total_s;
    logic                   window_done_s;
    logic                   over_s;

    for (genvar g = 0; g < PARALLEL; g++) begin : g_lane
        sat_lane_classify #(
            .DIN_WIDTH(DIN_WIDTH),
            .DIN_INT  (DIN_INT)
        ) u_classify (
            .din    (din[DIN_WIDTH*g +: DIN_WIDTH]),
            .pos_sat(pos_flags_s[g]),
            .neg_sat(neg_flags_s[g])
        );
    end

    // Per-beat popcount of the registered lane flags.
    always_comb begin
        pos_pc_s = '0;
        neg_pc_s = '0;
        for (int i = 0; i < PARALLEL; i++) begin
            pos_pc_s = pos_pc_s + PC_W'(pos_flags_r[i]);
            neg_pc_s = neg_pc_s + PC_W'(neg_flags_r[i]);
        end
    end

    // Window-end detection, running totals including the current beat, and threshold compare.
    always_comb begin
        window_done_s = s2_valid_r && (win_cnt_r == WIN_LAST);
        pos_total_s   = pos_acc_r + CNT_W'(pos_pc_r);
        neg_total_s   = neg_acc_r + CNT_W'(neg_pc_r);
        over_s        = ({1'b0, pos_total_s} + {1'b0, neg_total_s}) > {1'b0, thresh};
    end

    // Stages 1 and 2: lane flags, then popcounts; clear drops in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_flags_r <= '0;
            neg_flags_r <= '0;
            s1_valid_r  <= 1'b0;
            pos_pc_r    <= '0;
            neg_pc_r    <= '0;
            s2_valid_r  <= 1'b0;
        end else if (clear) begin
            s1_valid_r  <= 1'b0;
            s2_valid_r  <= 1'b0;
        end else begin
            pos_flags_r <= pos_flags_s;
            neg_flags_r <= neg_flags_s;
            s1_valid_r  <= din_valid;
            pos_pc_r    <= pos_pc_s;
            neg_pc_r    <= neg_pc_s;
            s2_valid_r  <= s1_valid_r;
        end
    end

    // Window counter and accumulators advance on valid stage-2 beats only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r <= '0;
            pos_acc_r <= '0;
            neg_acc_r <= '0;
        end else if (clear) begin
            win_cnt_r <= '0;
            pos_acc_r <= '0;
            neg_acc_r <= '0;
        end else if (s2_valid_r) begin
            win_cnt_r <= win_cnt_r + 1'b1;
            if (window_done_s) begin
                pos_acc_r <= '0;
                neg_acc_r <= '0;
            end else begin
                pos_acc_r <= pos_total_s;
                neg_acc_r <= neg_total_s;
            end
        end
    end

    // Result register and handshake; a new result always wins over acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_count   <= '0;
            neg_count   <= '0;
            over_thresh <= 1'b0;
            dout_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else if (clear) begin
            dout_valid  <= 1'b0;
            overrun     <= 1'b0;
        end else if (window_done_s) begin
            pos_count   <= pos_total_s;
            neg_count   <= neg_total_s;
            over_thresh <= over_s;
            dout_valid  <= 1'b1;
            if (dout_valid && !dout_ready) begin
                overrun <= 1'b1;
            end
        end else if (dout_valid && dout_ready) begin
            dout_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sat_monitor.sv
// Directed self-checking bench for sat_monitor with a 16-beat window.
module tb_sat_monitor;

    localparam int CNT_W = 7;

    logic             clk;
    logic             rst_n;
    logic [63:0]      din;
    logic             din_valid;
    logic             clear;
    logic [CNT_W-1:0] thresh;
    logic [CNT_W-1:0] pos_count;
    logic [CNT_W-1:0] neg_count;
    logic             over_thresh;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;

    int n_cmp;
    int n_err;

    // Lane order in the word is {lane3, lane2, lane1, lane0}.
    localparam logic [63:0] D_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] D_SAT  = 64'h1234_1234_8000_7FFF;
    // With 5 integer bits: 0x7800 -> 01111 (pos), 0x77FF -> 01110 (not),
    // 0x87FF -> 10000 (neg), 0x8800 -> 10001 (not).
    localparam logic [63:0] D_ALT0 = 64'h0000_0000_87FF_7800;
    localparam logic [63:0] D_ALT1 = 64'h0000_0000_8800_77FF;

    sat_monitor #(
        .PARALLEL   (4),
        .DIN_WIDTH  (16),
        .DIN_INT    (5),
        .WINDOW_LOG2(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .clear      (clear),
        .thresh     (thresh),
        .pos_count  (pos_count),
        .neg_count  (neg_count),
        .over_thresh(over_thresh),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n valid beats alternating d_even/d_odd, with gap idle cycles between beats.
    task automatic drive_beats(input logic [63:0] d_even, input logic [63:0] d_odd,
                               input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            din       = (i % 2 == 0) ? d_even : d_odd;
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            if (i < n - 1) begin
                for (int j = 0; j < gap; j++) tick();
            end
        end
        din_valid = 1'b0;
    endtask

    // Edges until dout_valid is seen, -1 if it never rises within the budget.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (dout_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (pos_count !== 7'd0) begin n_err++; $display("FAIL reset_pos: got %0d want 0", pos_count); end
        n_cmp++; if (neg_count !== 7'd0) begin n_err++; $display("FAIL reset_neg: got %0d want 0", neg_count); end
        n_cmp++; if ({over_thresh, dout_valid, overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {over_thresh, dout_valid, overrun}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_window();
        int lat;
        dout_ready = 1'b1;
        thresh     = 7'd0;
        drive_beats(D_ZERO, D_ZERO, 16, 0);
        wait_result(lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL zero_latency: got %0d want 2", lat); end
        n_cmp++; if (pos_count !== 7'd0 || neg_count !== 7'd0) begin n_err++; $display("FAIL zero_counts: got %0d/%0d want 0/0", pos_count, neg_count); end
        n_cmp++; if (over_thresh !== 1'b0) begin n_err++; $display("FAIL zero_over: got %b want 0", over_thresh); end
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL zero_pulse: got %b want 0", dout_valid); end
    endtask

    task automatic test_threshold();
        int lat;
        thresh = 7'd31;
        drive_beats(D_SAT, D_SAT, 16, 0);
        wait_result(lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL sat_latency: got %0d want 2", lat); end
        n_cmp++; if (pos_count !== 7'd16 || neg_count !== 7'd16) begin n_err++; $display("FAIL sat_counts: got %0d/%0d want 16/16", pos_count, neg_count); end
        n_cmp++; if (over_thresh !== 1'b1) begin n_err++; $display("FAIL sat_over31: got %b want 1", over_thresh); end
        thresh = 7'd32;
        drive_beats(D_SAT, D_SAT, 16, 0);
        wait_result(lat);
        n_cmp++; if (pos_count !== 7'd16 || neg_count !== 7'd16) begin n_err++; $display("FAIL sat2_counts: got %0d/%0d want 16/16", pos_count, neg_count); end
        n_cmp++; if (over_thresh !== 1'b0) begin n_err++; $display("FAIL sat_over32: got %b want 0", over_thresh); end
    endtask

    task automatic test_fraction();
        int lat;
        thresh = 7'd31;
        drive_beats(D_ALT0, D_ALT1, 16, 0);
        wait_result(lat);
        n_cmp++; if (pos_count !== 7'd8 || neg_count !== 7'd8) begin n_err++; $display("FAIL frac_counts: got %0d/%0d want 8/8", pos_count, neg_count); end
        n_cmp++; if (over_thresh !== 1'b0) begin n_err++; $display("FAIL frac_over: got %b want 0", over_thresh); end
    endtask

    task automatic test_sparse_valid();
        int lat;
        thresh = 7'd31;
        drive_beats(D_SAT, D_SAT, 8, 1);
        tick();
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL sparse_early: got %b want 0", dout_valid); end
        drive_beats(D_SAT, D_SAT, 8, 1);
        wait_result(lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL sparse_latency: got %0d want 2", lat); end
        n_cmp++; if (pos_count !== 7'd16 || neg_count !== 7'd16 || over_thresh !== 1'b1) begin n_err++; $display("FAIL sparse_result: got %0d/%0d/%b want 16/16/1", pos_count, neg_count, over_thresh); end
    endtask

    task automatic test_overrun();
        int lat;
        dout_ready = 1'b0;
        drive_beats(D_SAT, D_SAT, 16, 0);
        wait_result(lat);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first: got %b want 0", overrun); end
        drive_beats(D_ALT0, D_ALT1, 16, 0);
        tick();
        tick();
        n_cmp++; if (pos_count !== 7'd8 || neg_count !== 7'd8) begin n_err++; $display("FAIL ovr_counts: got %0d/%0d want 8/8", pos_count, neg_count); end
        n_cmp++; if (overrun !== 1'b1 || dout_valid !== 1'b1) begin n_err++; $display("FAIL ovr_flags: got ovr=%b vld=%b want 1/1", overrun, dout_valid); end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ovr_accept: got %b want 0", dout_valid); end
        tick();
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        n_cmp++; if (pos_count !== 7'd8) begin n_err++; $display("FAIL clear_keeps: got %0d want 8", pos_count); end
    endtask

    task automatic test_back_to_back();
        int lat;
        dout_ready = 1'b0;
        thresh     = 7'd31;
        drive_beats(D_SAT, D_SAT, 16, 0);
        wait_result(lat);
        drive_beats(D_ALT0, D_ALT1, 16, 0);
        tick();
        // Accept the pending result in the same cycle the new one loads.
        dout_ready = 1'b1;
        tick();
        n_cmp++; if (dout_valid !== 1'b1 || pos_count !== 7'd8) begin n_err++; $display("FAIL b2b_load: got vld=%b pos=%0d want 1/8", dout_valid, pos_count); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b want 0", dout_valid); end
    endtask

    task automatic test_clear_and_reset();
        int lat;
        dout_ready = 1'b1;
        drive_beats(D_SAT, D_SAT, 8, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL clear_nores: got %b want 0", dout_valid); end
        drive_beats(D_SAT, D_SAT, 15, 0);
        tick();
        tick();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL clear_15beats: got %b want 0", dout_valid); end
        drive_beats(D_SAT, D_SAT, 1, 0);
        wait_result(lat);
        n_cmp++; if (pos_count !== 7'd16 || neg_count !== 7'd16) begin n_err++; $display("FAIL clear_fresh: got %0d/%0d want 16/16", pos_count, neg_count); end
        drive_beats(D_SAT, D_SAT, 5, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pos_count !== 7'd0 || neg_count !== 7'd0) begin n_err++; $display("FAIL async_counts: got %0d/%0d want 0/0", pos_count, neg_count); end
        n_cmp++; if ({over_thresh, dout_valid, overrun} !== 3'b000) begin n_err++; $display("FAIL async_flags: got %b want 000", {over_thresh, dout_valid, overrun}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        din        = D_ZERO;
        din_valid  = 1'b0;
        clear      = 1'b0;
        thresh     = 7'd0;
        dout_ready = 1'b1;
        test_reset();
        test_zero_window();
        test_threshold();
        test_fraction();
        test_sparse_valid();
        test_overrun();
        test_back_to_back();
        test_clear_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
